// File: rtl/sc_pkg.sv
// Shared types and helpers for the parallel stochastic-to-binary converter.
package sc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Last row and last column are not fed by the edge stage.
    function automatic bit is_border(input int k, input int m, input int n);
        return ((k / n) == (m - 1)) || ((k % n) == (n - 1));
    endfunction

endpackage

// File: rtl/sc_s2b_counter.sv
// Single-pixel ones counter: clear, then add the incoming bit on each enabled cycle.
module sc_s2b_counter #(
    parameter int CW = 9
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_clr,
    input  logic          i_en,
    input  logic          i_bit,
    output logic [CW-1:0] o_count
);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            r_count <= '0;
        end else if (i_en && i_bit) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/sc_par_s2b.sv
// Parallel stochastic-to-binary converter: counts ones over L valid bits for every
// interior pixel and holds the result behind a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for start; counts hold the last result
// RUN   | accumulating bits on every bit_valid cycle
// DONE  | counts final and frozen until out_ready
module sc_par_s2b
    import sc_pkg::*;
#(
    parameter  int M  = 32,
    parameter  int N  = 32,
    parameter  int L  = 256,
    localparam int CW = $clog2(L + 1)
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_start,
    input  logic                     i_bit_valid,
    input  logic [M*N-1:0]           i_s,
    output logic                     o_busy,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [M*N-1:0][CW-1:0]   o_count
);

    localparam int IW = $clog2(L);

    state_t        r_state;
    state_t        w_state_next;
    logic [IW-1:0] r_idx;
    logic          w_clr;
    logic          w_en;
    logic          w_last;
    logic          w_unused_s;

    assign w_clr  = (r_state == IDLE) && i_start;
    assign w_en   = (r_state == RUN) && i_bit_valid;
    assign w_last = w_en && (r_idx == IW'(L - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (i_start)     w_state_next = RUN;
            RUN:     if (w_last)      w_state_next = DONE;
            DONE:    if (i_out_ready) w_state_next = IDLE;
            default:                  w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || w_clr || w_last) begin
            r_idx <= '0;
        end else if (w_en) begin
            r_idx <= r_idx + IW'(1);
        end
    end

    assign o_busy      = (r_state == RUN);
    assign o_out_valid = (r_state == DONE);

    // Border bits of i_s are intentionally ignored; they may be undriven.
    assign w_unused_s = ^i_s;

    for (genvar k = 0; k < M * N; k++) begin : g_pix
        if (is_border(k, M, N)) begin : g_border
            assign o_count[k] = '0;
        end else begin : g_interior
            sc_s2b_counter #(
                .CW (CW)
            ) u_cnt (
                .i_clk   (i_clk),
                .i_reset (i_reset),
                .i_clr   (w_clr),
                .i_en    (w_en),
                .i_bit   (i_s[k]),
                .o_count (o_count[k])
            );
        end
    end

endmodule

// File: tb/tb_sc_par_s2b.sv
// Self-checking bench for sc_par_s2b with a 4x4 image and 16-bit streams.
module tb_sc_par_s2b;

    localparam int M  = 4;
    localparam int N  = 4;
    localparam int L  = 16;
    localparam int P  = M * N;
    localparam int CW = $clog2(L + 1);

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               bit_valid;
    logic [P-1:0]       s;
    logic               busy;
    logic               out_valid;
    logic               out_ready;
    logic [P-1:0][CW-1:0] count;

    sc_par_s2b #(.M(M), .N(N), .L(L)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_start     (start),
        .i_bit_valid (bit_valid),
        .i_s         (s),
        .o_busy      (busy),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_count     (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [P-1:0] pat_even;
        logic [P-1:0] pat_odd;
        int           stall;
        bit           border_x;
        int           exp_total;
    } vec_t;

    typedef struct {
        int cnt [P];
    } exp_t;

    exp_t q_exp [$];
    exp_t last_exp;
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic bit bord(input int k);
        return ((k / N) == (M - 1)) || ((k % N) == (N - 1));
    endfunction

    task automatic cmp(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        for (int k = 0; k < P; k++) cmp($sformatf("%s cnt[%0d]", tag, k), int'(count[k]), 0);
    endtask

    task automatic check_result(input string tag, input int exp_total);
        exp_t e;
        int   tot;
        if (q_exp.size() == 0) begin
            cmp({tag, " scoreboard_empty"}, 0, 1);
            return;
        end
        e = q_exp.pop_front();
        last_exp = e;
        tot = 0;
        for (int k = 0; k < P; k++) begin
            cmp($sformatf("%s cnt[%0d]", tag, k), int'(count[k]), e.cnt[k]);
            tot += int'(count[k]);
        end
        cmp({tag, " total"}, tot, exp_total);
    endtask

    // Drives a full conversion; with skip_start the DUT is assumed already in RUN.
    task automatic run_conv(input string tag, input vec_t v, input bit skip_start);
        exp_t         e;
        logic [P-1:0] val;
        int           nbits;
        int           cyc;
        bit           early;
        bit           bv;
        nbits = 0;
        cyc   = 0;
        early = 0;
        for (int k = 0; k < P; k++) e.cnt[k] = 0;
        if (!skip_start) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        cmp({tag, " busy_after_start"}, int'(busy), 1);
        while (nbits < L && cyc < 200) begin
            bv  = !(v.stall != 0 && (cyc % v.stall) == v.stall - 1);
            val = (nbits % 2 == 0) ? v.pat_even : v.pat_odd;
            bit_valid = bv;
            for (int k = 0; k < P; k++) s[k] = (v.border_x && bord(k)) ? 1'bx : val[k];
            if (bv) begin
                for (int k = 0; k < P; k++) if (!bord(k)) e.cnt[k] += int'(val[k]);
                nbits++;
                if (nbits == L) q_exp.push_back(e);
            end
            tick();
            cyc++;
            if (nbits < L && out_valid) early = 1'b1;
        end
        bit_valid = 1'b0;
        s = '0;
        cmp({tag, " bits_within_budget"}, nbits, L);
        cmp({tag, " no_early_valid"}, int'(early), 0);
        cmp({tag, " out_valid_after_last"}, int'(out_valid), 1);
        cmp({tag, " busy_in_done"}, int'(busy), 0);
        check_result(tag, v.exp_total);
    endtask

    task automatic ack(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        cmp({tag, " valid_drop"}, int'(out_valid), 0);
        cmp({tag, " idle_busy"}, int'(busy), 0);
    endtask

    vec_t vecs [5];

    initial begin
        vecs[0] = '{16'hFFFF, 16'hFFFF, 0, 1'b0, 144};
        vecs[1] = '{16'h0020, 16'h0000, 3, 1'b0, 8};
        vecs[2] = '{16'h0000, 16'hFFFF, 0, 1'b0, 72};
        vecs[3] = '{16'hA5A5, 16'h0F0F, 2, 1'b0, 88};
        vecs[4] = '{16'hFFFF, 16'h0000, 4, 1'b1, 72};

        reset = 1'b1; start = 1'b0; bit_valid = 1'b0; s = '0; out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        cmp("reset out_valid", int'(out_valid), 0);
        cmp("reset busy", int'(busy), 0);
        check_zero("reset");

        for (int i = 0; i < 5; i++) begin
            run_conv($sformatf("vec%0d", i), vecs[i], 1'b0);
            ack($sformatf("vec%0d", i));
        end

        // DONE must hold through stimulus noise and start pulses until out_ready.
        run_conv("hold", vecs[2], 1'b0);
        for (int c = 0; c < 20; c++) begin
            s = P'($urandom);
            bit_valid = c[0];
            start = c[1];
            tick();
            cmp($sformatf("hold%0d valid", c), int'(out_valid), 1);
            cmp($sformatf("hold%0d cnt5", c), int'(count[5]), last_exp.cnt[5]);
            cmp($sformatf("hold%0d cnt10", c), int'(count[10]), last_exp.cnt[10]);
            cmp($sformatf("hold%0d cnt15", c), int'(count[15]), 0);
        end
        start = 1'b0; bit_valid = 1'b0; s = '0;
        ack("hold");
        cmp("hold kept_cnt0", int'(count[0]), last_exp.cnt[0]);

        // Reset partway through a run discards the partial result.
        start = 1'b1;
        tick();
        start = 1'b0;
        bit_valid = 1'b1;
        s = '1;
        for (int c = 0; c < 7; c++) tick();
        cmp("midrst busy_before", int'(busy), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bit_valid = 1'b0;
        s = '0;
        cmp("midrst busy", int'(busy), 0);
        cmp("midrst out_valid", int'(out_valid), 0);
        check_zero("midrst");
        tick();
        cmp("midrst still_idle", int'(busy), 0);
        run_conv("after_rst", vecs[0], 1'b0);

        // Handshake and start together: start is dropped, the next one is taken.
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        out_ready = 1'b0;
        cmp("b2b start_ignored", int'(busy), 0);
        cmp("b2b valid_drop", int'(out_valid), 0);
        cmp("b2b counts_held", int'(count[0]), 16);
        tick();
        start = 1'b0;
        cmp("b2b started", int'(busy), 1);
        check_zero("b2b cleared");
        run_conv("b2b", vecs[3], 1'b1);
        ack("b2b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
